pca9685_sequencer: RTL
======================

Name: pca9685_sequencer

Overview:
Upstream command stage for the I2C controller. After reset it issues the PCA9685 initialisation writes: sleep, prescale and wake, followed by the oscillator settle delay. It then accepts per-channel PWM requests and expands each one into the four LEDn register writes. Each write is one transaction presented to the I2C controller through an execute/busy handshake.

Parameters:
TARGET_ADDR, 7'h40, 7-bit I2C address of the PCA9685 target
PRESCALE, 8'd121, value written to the PRESCALE register (0xFE); 121 gives about 50 Hz
WAKE_DELAY, 16'd13500, clk_i cycles to wait after the wake write (500 us at 27 MHz)
ACCEPT_TIMEOUT, 16'd4096, maximum clk_i cycles from execute_o high to synchronised busy seen high
DONE_TIMEOUT, 20'd200000, maximum clk_i cycles from synchronised busy high to synchronised busy low

Ports:
clk_i  in  1  system clock
rst_ni  in  1  reset; asynchronous, active-low
req_valid_i  in  1  channel update request valid
req_ready_o  out  1  high when a request can be accepted
req_channel_i  in  4  PWM channel number, 0..15
req_on_i  in  12  ON count
req_off_i  in  12  OFF count
init_done_o  out  1  high once the init sequence has completed; sticky
error_o  out  1  transaction timeout; sticky until reset
address_o  out  7  to the controller's address input
rw_o  out  1  to the controller's rw input; always 0 (write)
register_id_o  out  8  register number for the current write
register_value_o  out  8  data byte for the current write
execute_o  out  1  transaction request, held high until accepted
busy_i  in  1  controller busy flag; comes from the slow I2C clock domain

Behaviour:
- Reset values: req_ready_o=0, init_done_o=0, error_o=0, execute_o=0, register_id_o=0, register_value_o=0. address_o=TARGET_ADDR and rw_o=0 at all times.
- busy_i passes through a 2-flop synchroniser into busy_s. Every use of busy below means busy_s.
- FSM states: INIT_LOAD, ISSUE, WAIT_ACCEPT, WAIT_DONE, DELAY, IDLE, CH_LOAD, FAULT. A 2-bit step index selects the write within a sequence.
- Init sequence, executed in order:
  - MODE1 (0x00) = 0x10
  - PRESCALE (0xFE) = PRESCALE
  - MODE1 = 0x00
  - DELAY for WAKE_DELAY cycles
  - then init_done_o=1 and go to IDLE
- IDLE: req_ready_o=1.
  - A request is accepted in the cycle where req_valid_i && req_ready_o.
  - In that cycle the block captures channel/on/off, drops req_ready_o the next cycle and enters CH_LOAD.
  - req_ready_o stays 0 in every state except IDLE.
- Channel expansion: base = 8'h06 + 4*channel, computed in 8 bits; channel 15 gives base 0x42. Writes, in order:
  - base+0 = on[7:0]
  - base+1 = {4'b0, on[11:8]}
  - base+2 = off[7:0]
  - base+3 = {4'b0, off[11:8]}
  - After the fourth write, return to IDLE.
- Each write goes through three states:
  - ISSUE: drives register_id_o/register_value_o, sets execute_o=1, goes to WAIT_ACCEPT.
  - WAIT_ACCEPT: execute_o stays 1 until busy=1 is seen, then execute_o=0 and go to WAIT_DONE.
  - WAIT_DONE: leave when busy=0.
  - register_id_o and register_value_o must be stable from ISSUE until WAIT_DONE exits, because the controller latches them late on its own clock.
- execute_o is a level signal, never a single-cycle pulse: the controller samples it on its slow clock.
- Timeouts: a cycle counter is cleared on entry to WAIT_ACCEPT and on entry to WAIT_DONE.
  - Overflow past ACCEPT_TIMEOUT or DONE_TIMEOUT goes to FAULT.
  - FAULT: error_o=1, execute_o=0, req_ready_o=0. FAULT is terminal until reset.
- req_valid_i while not ready is ignored; no queuing. Request data is only sampled at acceptance.
- Reset mid-transaction (async): all outputs return to their reset values immediately, and the init sequence restarts from step 0 after reset deasserts.
- If busy is already 1 on entry to WAIT_ACCEPT, that counts as accept; assumes the previous transaction fully ended in WAIT_DONE.
- Latency, request accept to first execute_o=1: 2 cycles (CH_LOAD, ISSUE).

Test Plan:
- Reset release with a model controller (busy high 5 cycles after execute, busy length 300 cycles), WAKE_DELAY=20 -> writes (0x00,0x10), (0xFE,121), (0x00,0x00), then ≥20 idle cycles, then init_done_o=1 and req_ready_o=1.
- Request ch=3, on=12'h123, off=12'hABC -> writes (0x12,0x23), (0x13,0x01), (0x14,0xBC), (0x15,0x0A); req_ready_o low throughout, high after the last busy fall.
- Request ch=15, on=0, off=12'hFFF -> registers 0x42..0x45 with values 0x00, 0x00, 0xFF, 0x0F.
- Model never raises busy, ACCEPT_TIMEOUT=64 -> error_o=1 within 67 cycles of execute_o rise; execute_o=0; later requests ignored.
- Assert rst_ni low during the second init write's WAIT_DONE -> outputs at reset values immediately; after release, the init restarts with MODE1=0x10.
- req_valid_i held high across a channel update -> exactly one acceptance per IDLE entry; back-to-back requests for ch 0 and ch 1 produce 8 writes in order.

Source files
------------

// File: rtl/pca9685_sequencer.sv
// PCA9685 command sequencer: runs the init writes (sleep, prescale, wake, settle delay) and then
// expands each channel request into four LEDn register writes using the I2C execute/busy handshake.
module pca9685_sequencer #(
  parameter logic [6:0]  TARGET_ADDR    = 7'h40,
  parameter logic [7:0]  PRESCALE       = 8'd121,
  parameter logic [15:0] WAKE_DELAY     = 16'd13500,
  parameter logic [15:0] ACCEPT_TIMEOUT = 16'd4096,
  parameter logic [19:0] DONE_TIMEOUT   = 20'd200000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_channel_i,
  input  logic [11:0] req_on_i,
  input  logic [11:0] req_off_i,
  output logic        init_done_o,
  output logic        error_o,
  output logic [6:0]  address_o,
  output logic        rw_o,
  output logic [7:0]  register_id_o,
  output logic [7:0]  register_value_o,
  output logic        execute_o,
  input  logic        busy_i
);

  typedef enum logic [2:0] {
    INIT_LOAD, ISSUE, WAIT_ACCEPT, WAIT_DONE, DELAY, IDLE, CH_LOAD, FAULT
  } state_e;

  localparam logic [19:0] WAKE_LIMIT   = {4'b0, WAKE_DELAY};
  localparam logic [19:0] ACCEPT_LIMIT = {4'b0, ACCEPT_TIMEOUT};

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic        in_init_q, in_init_d;
  logic [19:0] cnt_q, cnt_d;
  logic [3:0]  ch_q, ch_d;
  logic [11:0] on_q, on_d, off_q, off_d;
  logic [7:0]  reg_id_q, reg_id_d, reg_val_q, reg_val_d;
  logic        exec_q, exec_d;
  logic        init_done_q, init_done_d;
  logic        busy_meta_q, busy_s;
  logic [7:0]  ch_base;

  // busy_i is produced on the slow I2C clock, so it is resynchronised before any decision uses it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_meta_q <= 1'b0;
      busy_s      <= 1'b0;
    end else begin
      busy_meta_q <= busy_i;
      busy_s      <= busy_meta_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= INIT_LOAD;
      step_q      <= 2'd0;
      in_init_q   <= 1'b1;
      cnt_q       <= 20'd0;
      ch_q        <= 4'd0;
      on_q        <= 12'd0;
      off_q       <= 12'd0;
      reg_id_q    <= 8'd0;
      reg_val_q   <= 8'd0;
      exec_q      <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      in_init_q   <= in_init_d;
      cnt_q       <= cnt_d;
      ch_q        <= ch_d;
      on_q        <= on_d;
      off_q       <= off_d;
      reg_id_q    <= reg_id_d;
      reg_val_q   <= reg_val_d;
      exec_q      <= exec_d;
      init_done_q <= init_done_d;
    end
  end

  assign ch_base = 8'h06 + {2'b00, ch_q, 2'b00};

  // register id/value are loaded once per write and held until the busy fall, as the controller samples them late
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    in_init_d   = in_init_q;
    cnt_d       = cnt_q;
    ch_d        = ch_q;
    on_d        = on_q;
    off_d       = off_q;
    reg_id_d    = reg_id_q;
    reg_val_d   = reg_val_q;
    exec_d      = exec_q;
    init_done_d = init_done_q;

    case (state_q)
      INIT_LOAD: begin
        in_init_d = 1'b1;
        case (step_q)
          2'd0:    begin reg_id_d = 8'h00; reg_val_d = 8'h10;    end
          2'd1:    begin reg_id_d = 8'hFE; reg_val_d = PRESCALE; end
          default: begin reg_id_d = 8'h00; reg_val_d = 8'h00;    end
        endcase
        state_d = ISSUE;
      end
      ISSUE: begin
        exec_d  = 1'b1;
        cnt_d   = 20'd0;
        state_d = WAIT_ACCEPT;
      end
      WAIT_ACCEPT: begin
        if (busy_s) begin
          exec_d  = 1'b0;
          cnt_d   = 20'd0;
          state_d = WAIT_DONE;
        end else if (cnt_q >= ACCEPT_LIMIT) begin
          exec_d  = 1'b0;
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      WAIT_DONE: begin
        if (!busy_s) begin
          if (in_init_q) begin
            if (step_q == 2'd2) begin
              cnt_d   = 20'd0;
              state_d = DELAY;
            end else begin
              step_d  = step_q + 2'd1;
              state_d = INIT_LOAD;
            end
          end else if (step_q == 2'd3) begin
            step_d  = 2'd0;
            state_d = IDLE;
          end else begin
            step_d  = step_q + 2'd1;
            state_d = CH_LOAD;
          end
        end else if (cnt_q >= DONE_TIMEOUT) begin
          state_d = FAULT;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      DELAY: begin
        if ((cnt_q + 20'd1) >= WAKE_LIMIT) begin
          init_done_d = 1'b1;
          step_d      = 2'd0;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      IDLE: begin
        if (req_valid_i) begin
          ch_d      = req_channel_i;
          on_d      = req_on_i;
          off_d     = req_off_i;
          step_d    = 2'd0;
          in_init_d = 1'b0;
          state_d   = CH_LOAD;
        end
      end
      CH_LOAD: begin
        reg_id_d = ch_base + {6'b0, step_q};
        case (step_q)
          2'd0:    reg_val_d = on_q[7:0];
          2'd1:    reg_val_d = {4'b0, on_q[11:8]};
          2'd2:    reg_val_d = off_q[7:0];
          default: reg_val_d = {4'b0, off_q[11:8]};
        endcase
        state_d = ISSUE;
      end
      FAULT: begin
        exec_d = 1'b0;
      end
      default: state_d = FAULT;
    endcase
  end

  assign req_ready_o      = (state_q == IDLE);
  assign error_o          = (state_q == FAULT);
  assign init_done_o      = init_done_q;
  assign execute_o        = exec_q;
  assign register_id_o    = reg_id_q;
  assign register_value_o = reg_val_q;
  assign address_o        = TARGET_ADDR;
  assign rw_o             = 1'b0;

endmodule
